jtframe_romrq_cache: RTL
========================

// Module: jtframe_romrq_cache
// PURPOSE
// - Multi-way, parametrised ROM request cache between a core-side ROM reader and the SDRAM controller.
// - Successor to the fixed two-entry 32-bit word cache: configurable way count, explicit request FSM,
//   latched request address, data-valid strobe and cache flush.
// - One instance per ROM region; the SDRAM arbiter answers req/addr_req with a 32-bit word plus we.
// PARAMETERS
// AW         18  byte/element address width of addr
// DW          8  output width: 8, 16 or 32; word = 32 bits holding 4, 2 or 1 elements
// WAYS        4  cache entries, 2..8; replacement is round-robin
// INVERT_A0   0  1 = swap element order inside a 16-bit half (lane select uses ~addr[0])
// PORTS
// clk      in   1   system clock
// rst      in   1   synchronous reset, active high
// cen      in   1   clock enable; all state except reset updates only when cen=1
// addr     in   AW  element address from the core
// addr_ok  in   1   addr is valid and data is wanted
// flush    in   1   invalidate all cached entries
// din      in   32  fill word from SDRAM
// we       in   1   din valid for the outstanding request
// req      out  1   registered; fill request outstanding
// addr_req out  AW  registered; word-aligned request address, stable while req=1
// dout     out  DW  registered element for addr
// data_ok  out  1   registered; dout matches the current addr
// BEHAVIOUR
// - Word alignment: DW=8 -> {addr[AW-1:2],2'b0}; DW=16 -> {addr[AW-1:1],1'b0}; DW=32 -> addr.
// - hit (combinational): any way has valid=1 and tag == aligned addr. A fill never duplicates a tag,
//   so at most one way can hit.
// - Reset: valid[*]=0, rr=0, state=IDLE, req=0, addr_req=0, dout=0, data_ok=0. Reset overrides cen.
// - FSM IDLE (on cen):
//   - addr_ok & !hit: req<=1, addr_req<=aligned addr, go to WAIT.
//   - Otherwise stay in IDLE.
// - FSM WAIT (on cen):
//   - req stays 1 and addr_req stays frozen, even if addr changes or addr_ok drops; there is no abort.
//   - On we: tag[rr]<=addr_req, data[rr]<=din, valid[rr]<=1, rr<=(rr+1)%WAYS, req<=0, go to IDLE.
//   - The next miss can raise req at the earliest one cen after the fill.
// - we while in IDLE is ignored: no write, rr unchanged.
// - Output (on cen):
//   - If addr_ok & hit: dout<=lane of the hit word, data_ok<=1.
//   - Otherwise data_ok<=0 and dout holds its value.
// - Lane select:
//   - DW=8: {addr[1], addr[0]^INVERT_A0}; lane 0 = din[7:0] ... lane 3 = din[31:24].
//   - DW=16: addr[0]^INVERT_A0; lane 0 = din[15:0].
//   - DW=32: whole word.
// - Latency:
//   - Hit: data_ok one cen after addr_ok is presented.
//   - Miss: req rises one cen after addr_ok. After the we cycle, data_ok rises on the next cen.
// - flush (on cen):
//   - Clears valid for all ways and leaves rr unchanged.
//   - flush in the same cycle as a fill: old entries are cleared and the newly written way ends valid.
//   - flush in WAIT without we: the request stays outstanding and completes normally.
// - rst during WAIT: req drops on the next clk edge; a later we is ignored until a new miss.
// TESTING
// - Hit/miss, DW=8, WAYS=4: addr=0x100, addr_ok=1 -> req=1, addr_req=0x100; we with din=0x44332211
//   -> next cen data_ok=1, dout=0x11. Then addr=0x103 -> dout=0x44 one cen later, req stays 0.
// - Round robin, WAYS=4: fill words 0x000, 0x004, 0x008, 0x00C, then 0x010 -> 0x010 replaces way 0.
//   A following read of 0x000 misses (req=1); a read of 0x004 still hits.
// - Address change in WAIT: miss 0x200, then addr=0x300 before we -> addr_req stays 0x200.
//   After we, 0x300 misses and req re-rises with addr_req=0x300.
// - flush: cache 0x400, pulse flush -> next read of 0x400 gives req=1, data_ok=0.
//   flush coincident with we -> only the new entry hits afterwards.
// - Stray we in IDLE with din=0xDEADBEEF: no entry changes; a prior hit on 0x100 still returns 0x11.
// - DW=16, INVERT_A0=1, din=0xBBBBAAAA: addr=0 -> dout=0xBBBB; addr=1 -> dout=0xAAAA.
//   rst asserted mid-WAIT -> req=0 and data_ok=0 on the next edge.

Source files
------------

// File: rtl/jtframe_romrq_cache.sv
// Multi-way, round-robin ROM request cache between a core-side ROM reader and the SDRAM controller.
// A miss raises req with a frozen word address; the returned word fills the next round-robin way.
module jtframe_romrq_cache #(
    parameter int AW        = 18,
    parameter int DW        = 8,
    parameter int WAYS      = 4,
    parameter int INVERT_A0 = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic [AW-1:0] addr,
    input  logic          addr_ok,
    input  logic          flush,
    input  logic [31:0]   din,
    input  logic          we,
    output logic          req,
    output logic [AW-1:0] addr_req,
    output logic [DW-1:0] dout,
    output logic          data_ok
);
    localparam int LANES = 32 / DW;
    localparam int LW    = LANES > 1 ? $clog2(LANES) : 1;
    localparam int RW    = $clog2(WAYS);
    localparam logic [AW-1:0] ALIGN_MASK = ~AW'(LANES - 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t          state, state_nx;
    logic [WAYS-1:0] valid;
    logic [AW-1:0]   tags  [WAYS];
    logic [31:0]     words [WAYS];
    logic [RW-1:0]   rr;
    logic [AW-1:0]   addr_al;
    logic            hit;
    logic [31:0]     hit_word;
    logic [DW-1:0]   lane_data;
    logic            fill;

    assign addr_al = addr & ALIGN_MASK;
    assign fill    = (state == WAIT) && we;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        hit      = 1'b0;
        hit_word = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[w] && tags[w] == addr_al) begin
                hit      = 1'b1;
                hit_word = words[w];
            end
        end
    end

    generate
        if (LANES == 1) begin : g_word
            assign lane_data = hit_word;
        end else begin : g_lane
            logic [LANES-1:0][DW-1:0] lanes;
            logic [LW-1:0]            lane;
            assign lanes     = hit_word;
            assign lane      = addr[LW-1:0] ^ LW'(INVERT_A0 != 0 ? 1 : 0);
            assign lane_data = lanes[lane];
        end
    endgenerate

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (addr_ok && !hit) state_nx = WAIT;
            WAIT:    if (we) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; the fill's valid[rr] write
    // comes after the flush clear, so the newly filled way survives a coincident flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            req      <= 1'b0;
            addr_req <= '0;
            valid    <= '0;
            rr       <= '0;
            dout     <= '0;
            data_ok  <= 1'b0;
        end else if (cen) begin
            state <= state_nx;
            req   <= state_nx == WAIT;
            if (state == IDLE && state_nx == WAIT) addr_req <= addr_al;
            if (flush) valid <= '0;
            if (fill) begin
                valid[rr] <= 1'b1;
                rr        <= (rr == RW'(WAYS - 1)) ? '0 : rr + 1'b1;
            end
            if (addr_ok && hit) begin
                dout    <= lane_data;
                data_ok <= 1'b1;
            end else begin
                data_ok <= 1'b0;
            end
        end
    end

    // NOTE: tag/data storage is not reset; the valid bits alone decide whether an entry is usable.
    always_ff @(posedge clk) begin
        if (!rst && cen && fill) begin
            tags[rr]  <= addr_req;
            words[rr] <= din;
        end
    end

endmodule
